// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the write-back / load stage.
//   - RESULTSRC encodings (ALU, load, PC+4; 2'b11 is reserved and writes nothing)
//   - load funct3 codes
//   - write-back FSM state encoding
//   - load_legal(): funct3 legality and natural-alignment check
package wb_pkg;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  // A load is issued only when funct3 names a real load and the
  // byte address is naturally aligned for that access size.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_LB, F3_LBU: load_legal = 1'b1;
      F3_LH, F3_LHU: load_legal = ~lo[0];
      F3_LW:         load_legal = (lo == 2'b00);
      default:       load_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the byte/half lane from a 32-bit read word and
// sign- or zero-extends it according to the load funct3.
//   funct3  - load type
//   addr_lo - byte offset within the word (byte lane = addr_lo, half lane = addr_lo[1])
//   word    - raw word from memory
//   result  - extended value for write-back
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_load_unit.sv
// wb_load_unit: write-back stage and sole driver of the register-file
// write port. ALU / PC+4 results are registered for one cycle; loads are
// serialised through a req/ack data-memory port, then lane-selected and
// extended before write-back.
//   CLK, RST_N          - clock, async active-low reset
//   EX_*                - retiring instruction from execute (valid/ready)
//   MEM_REQ/ADDR/ACK/RDATA - word-aligned read port, multi-cycle
//   WE3, A3, WD3        - register-file write port
//   MISALIGN            - one-cycle pulse when a load is dropped
module wb_load_unit
  import wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EX_VALID,
  output logic                 EX_READY,
  input  logic                 EX_REGWRITE,
  input  logic [REGADDR_W-1:0] EX_RD,
  input  logic [1:0]           EX_RESULTSRC,
  input  logic [2:0]           EX_FUNCT3,
  input  logic [XLEN-1:0]      EX_ALURESULT,
  input  logic [XLEN-1:0]      EX_PCPLUS4,
  output logic                 MEM_REQ,
  output logic [XLEN-1:0]      MEM_ADDR,
  input  logic                 MEM_ACK,
  input  logic [XLEN-1:0]      MEM_RDATA,
  output logic                 WE3,
  output logic [REGADDR_W-1:0] A3,
  output logic [XLEN-1:0]      WD3,
  output logic                 MISALIGN
);

  wb_state_e            state_q, state_d;
  logic                 req_q, req_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [REGADDR_W-1:0] rd_q, rd_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           lo_q, lo_d;
  logic                 rw_q, rw_d;
  logic                 we3_q, we3_d;
  logic [REGADDR_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]      wd3_q, wd3_d;
  logic                 mis_q, mis_d;
  logic [XLEN-1:0]      ext_data;
  logic                 accept;
  logic                 nl_we;

  load_extend u_ext (
    .funct3 (f3_q),
    .addr_lo(lo_q),
    .word   (MEM_RDATA),
    .result (ext_data)
  );

  assign EX_READY = (state_q != ST_WAIT_MEM);
  assign accept   = EX_VALID & EX_READY;
  assign nl_we    = EX_REGWRITE & (EX_RD != '0);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    rw_d    = rw_q;
    we3_d   = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    mis_d   = 1'b0;

    if (state_q == ST_WAIT_MEM) begin
      // Request and address hold until the ack edge.
      if (MEM_ACK) begin
        req_d   = 1'b0;
        we3_d   = rw_q & (rd_q != '0);
        a3_d    = rd_q;
        wd3_d   = ext_data;
        state_d = ST_WRITE;
      end
    end else begin
      // IDLE and WRITE both accept; WRITE only lasts one cycle.
      state_d = ST_IDLE;
      if (accept) begin
        case (EX_RESULTSRC)
          RS_ALU, RS_PC4: begin
            we3_d   = nl_we;
            a3_d    = EX_RD;
            wd3_d   = (EX_RESULTSRC == RS_PC4) ? EX_PCPLUS4 : EX_ALURESULT;
            state_d = nl_we ? ST_WRITE : ST_IDLE;
          end
          RS_LOAD: begin
            if (load_legal(EX_FUNCT3, EX_ALURESULT[1:0])) begin
              req_d   = 1'b1;
              addr_d  = {EX_ALURESULT[XLEN-1:2], 2'b00};
              rd_d    = EX_RD;
              f3_d    = EX_FUNCT3;
              lo_d    = EX_ALURESULT[1:0];
              rw_d    = EX_REGWRITE;
              state_d = ST_WAIT_MEM;
            end else begin
              mis_d = 1'b1;
            end
          end
          default: ;  // reserved source: retire silently
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      rw_q    <= 1'b0;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      rw_q    <= rw_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      mis_q   <= mis_d;
    end
  end

  assign MEM_REQ  = req_q;
  assign MEM_ADDR = addr_q;
  assign WE3      = we3_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign MISALIGN = mis_q;

endmodule

// File: tb/tb_wb_load_unit.sv
module tb_wb_load_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EX_VALID = 1'b0;
  logic        EX_READY;
  logic        EX_REGWRITE = 1'b0;
  logic [4:0]  EX_RD = '0;
  logic [1:0]  EX_RESULTSRC = '0;
  logic [2:0]  EX_FUNCT3 = '0;
  logic [31:0] EX_ALURESULT = '0;
  logic [31:0] EX_PCPLUS4 = '0;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = '0;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        MISALIGN;

  wb_load_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_REGWRITE(EX_REGWRITE),
    .EX_RD(EX_RD), .EX_RESULTSRC(EX_RESULTSRC), .EX_FUNCT3(EX_FUNCT3),
    .EX_ALURESULT(EX_ALURESULT), .EX_PCPLUS4(EX_PCPLUS4),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .WE3(WE3), .A3(A3), .WD3(WD3), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          wt;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every register-file write must match the oldest expected one.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && WE3 !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: A3=%0d WD3=0x%08h at %0t", A3, WD3, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_a3", 32'(A3), 32'(e.rd));
        chk("wr_wd3", WD3, e.wd);
      end
    end
  end

  task automatic drive(input vec_t v);
    EX_VALID = 1'b1;
    EX_RESULTSRC = v.rs;
    EX_FUNCT3 = v.f3;
    EX_REGWRITE = v.rw;
    EX_RD = v.rd;
    EX_ALURESULT = v.alu;
    EX_PCPLUS4 = v.pc4;
    if (v.exp_we) exp_q.push_back('{rd: v.rd, wd: v.exp_wd});
  endtask

  task automatic run_vec(input vec_t v);
    logic legal;
    logic [31:0] waddr;
    legal = (v.rs == 2'b01) && !v.exp_mis;
    waddr = {v.alu[31:2], 2'b00};
    @(negedge CLK);
    drive(v);
    @(posedge CLK); #1;
    EX_VALID = 1'b0;
    chk("mem_req_rise", 32'(MEM_REQ), 32'(legal));
    chk("misalign", 32'(MISALIGN), 32'(v.exp_mis));
    if (legal) begin
      chk("mem_addr", MEM_ADDR, waddr);
      chk("ex_ready_wait", 32'(EX_READY), 32'd0);
      for (int i = 0; i < v.wt; i++) begin
        @(posedge CLK); #1;
        chk("mem_addr_hold", MEM_ADDR, waddr);
        chk("mem_req_hold", 32'(MEM_REQ), 32'd1);
      end
      MEM_ACK = 1'b1;
      MEM_RDATA = v.rdata;
      @(posedge CLK); #1;
      MEM_ACK = 1'b0;
      MEM_RDATA = 32'hA5A5_A5A5;
      chk("mem_req_fall", 32'(MEM_REQ), 32'd0);
      chk("ex_ready_after", 32'(EX_READY), 32'd1);
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("misalign_clear", 32'(MISALIGN), 32'd0);
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  vec_t vecs[$];

  initial begin
    //           rs     f3      rw    rd     alu            pc4          rdata         wt exp_we exp_wd        exp_mis
    vecs.push_back('{2'b00, 3'b000, 1'b1, 5'd5,  32'd42,        32'd0,       32'd0,        0, 1'b1, 32'd42,        1'b0});
    vecs.push_back('{2'b10, 3'b000, 1'b1, 5'd0,  32'd0,         32'h104,     32'd0,        0, 1'b0, 32'd0,         1'b0});
    vecs.push_back('{2'b10, 3'b000, 1'b1, 5'd4,  32'd0,         32'h204,     32'd0,        0, 1'b1, 32'h204,       1'b0});
    vecs.push_back('{2'b01, 3'b000, 1'b1, 5'd10, 32'h1003,      32'd0,       32'h80FF1234, 3, 1'b1, 32'hFFFFFF80,  1'b0});
    vecs.push_back('{2'b01, 3'b100, 1'b1, 5'd10, 32'h1003,      32'd0,       32'h80FF1234, 3, 1'b1, 32'h00000080,  1'b0});
    vecs.push_back('{2'b01, 3'b001, 1'b1, 5'd11, 32'h2002,      32'd0,       32'h9ABC0000, 0, 1'b1, 32'hFFFF9ABC,  1'b0});
    vecs.push_back('{2'b01, 3'b101, 1'b1, 5'd11, 32'h2002,      32'd0,       32'h9ABC0000, 0, 1'b1, 32'h00009ABC,  1'b0});
    vecs.push_back('{2'b01, 3'b010, 1'b1, 5'd12, 32'h3001,      32'd0,       32'd0,        0, 1'b0, 32'd0,         1'b1});
    vecs.push_back('{2'b01, 3'b011, 1'b1, 5'd12, 32'h3000,      32'd0,       32'd0,        0, 1'b0, 32'd0,         1'b1});
    vecs.push_back('{2'b01, 3'b001, 1'b1, 5'd12, 32'h2001,      32'd0,       32'd0,        0, 1'b0, 32'd0,         1'b1});
    vecs.push_back('{2'b01, 3'b010, 1'b1, 5'd12, 32'h4000,      32'd0,       32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF,  1'b0});
    vecs.push_back('{2'b01, 3'b000, 1'b1, 5'd13, 32'h1001,      32'd0,       32'h12347F00, 2, 1'b1, 32'h0000007F,  1'b0});
    vecs.push_back('{2'b01, 3'b000, 1'b1, 5'd0,  32'h1001,      32'd0,       32'h12347F00, 0, 1'b0, 32'd0,         1'b0});
    vecs.push_back('{2'b01, 3'b001, 1'b0, 5'd14, 32'h2000,      32'd0,       32'h00008001, 0, 1'b0, 32'd0,         1'b0});
    vecs.push_back('{2'b01, 3'b001, 1'b1, 5'd15, 32'h2000,      32'd0,       32'h00008001, 1, 1'b1, 32'hFFFF8001,  1'b0});
    vecs.push_back('{2'b11, 3'b000, 1'b1, 5'd3,  32'd99,        32'd0,       32'd0,        0, 1'b0, 32'd0,         1'b0});
    vecs.push_back('{2'b00, 3'b000, 1'b0, 5'd6,  32'd77,        32'd0,       32'd0,        0, 1'b0, 32'd0,         1'b0});

    // Reset state
    #1;
    chk("rst_we3", 32'(WE3), 32'd0);
    chk("rst_a3", 32'(A3), 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    chk("rst_misalign", 32'(MISALIGN), 32'd0);
    chk("rst_ex_ready", 32'(EX_READY), 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: ALU write immediately followed by a load accepted in WRITE.
    @(negedge CLK);
    drive('{2'b00, 3'b000, 1'b1, 5'd8, 32'h55, 32'd0, 32'd0, 0, 1'b1, 32'h55, 1'b0});
    @(posedge CLK); #1;
    chk("b2b_ready_in_write", 32'(EX_READY), 32'd1);
    drive('{2'b01, 3'b010, 1'b1, 5'd9, 32'h6000, 32'd0, 32'd0, 0, 1'b1, 32'h01020304, 1'b0});
    @(posedge CLK); #1;
    EX_VALID = 1'b0;
    chk("b2b_mem_req", 32'(MEM_REQ), 32'd1);
    chk("b2b_mem_addr", MEM_ADDR, 32'h6000);
    MEM_ACK = 1'b1;
    MEM_RDATA = 32'h01020304;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("b2b_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset in the middle of a load: request drops at once, late ack ignored.
    @(negedge CLK);
    drive('{2'b01, 3'b010, 1'b1, 5'd14, 32'h5000, 32'd0, 32'd0, 0, 1'b0, 32'd0, 1'b0});
    @(posedge CLK); #1;
    EX_VALID = 1'b0;
    chk("rml_mem_req", 32'(MEM_REQ), 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("rml_req_low", 32'(MEM_REQ), 32'd0);
    chk("rml_addr_low", MEM_ADDR, 32'd0);
    chk("rml_ready", 32'(EX_READY), 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    MEM_ACK = 1'b1;
    MEM_RDATA = 32'hCAFEF00D;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rml_no_req", 32'(MEM_REQ), 32'd0);
    run_vec('{2'b00, 3'b000, 1'b1, 5'd7, 32'h1234_5678, 32'd0, 32'd0, 0, 1'b1, 32'h1234_5678, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
- Write-back stage directly upstream of the register file; sole driver of its write port (WE3, A3, WD3).
- Accepts one retiring instruction per handshake from execute; result source is ALU result, PC+4, or a load.
- Loads fetch a word through a multi-cycle req/ack data-memory port, then byte/half-select and extend before write-back.
- Serialises loads; non-load results pass through in one registered cycle.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- REGADDR_W, 5, register index width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EX_VALID  in  1  execute presents an instruction.
- EX_READY  out  1  stage can accept this cycle.
- EX_REGWRITE  in  1  instruction writes rd.
- EX_RD  in  5  destination register.
- EX_RESULTSRC  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (no write).
- EX_FUNCT3  in  3  load type.
- EX_ALURESULT  in  32  ALU result / load byte address.
- EX_PCPLUS4  in  32  PC+4.
- MEM_REQ  out  1  read request to data memory.
- MEM_ADDR  out  32  word-aligned address ({addr[31:2],2'b00}).
- MEM_ACK  in  1  memory returns data this cycle.
- MEM_RDATA  in  32  read word, valid with MEM_ACK.
- WE3  out  1  register-file write enable.
- A3  out  5  register-file write address.
- WD3  out  32  register-file write data.
- MISALIGN  out  1  one-cycle pulse: misaligned or illegal load dropped.

Behaviour:
- Reset (async, RST_N=0): state IDLE; WE3=0, A3=0, WD3=0, MEM_REQ=0, MEM_ADDR=0, MISALIGN=0; captured instruction fields cleared. Outputs take reset values immediately; reset during WAIT_MEM abandons the load, and a late MEM_ACK after reset is ignored.
- States: IDLE, WAIT_MEM, WRITE.
- EX_READY = (state != WAIT_MEM), combinational. Accept = EX_VALID & EX_READY at a rising edge.
- Non-load accept (RESULTSRC 00/10) at edge N:
  - WE3/A3/WD3 are registered and valid for cycle N+1; the register file commits at edge N+2.
  - WE3 = EX_REGWRITE & (EX_RD != 0).
  - State goes to WRITE, or stays IDLE if WE3 would be 0.
- RESULTSRC 11: accepted, no write, no flag.
- Load accept at edge N:
  - Alignment checked first. LW needs addr[1:0]=00; LH/LHU need addr[0]=0. Legal funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Misaligned or illegal funct3: MISALIGN=1 in cycle N+1, no request, no write, state IDLE.
  - Otherwise: state WAIT_MEM; MEM_REQ=1 from cycle N+1; MEM_ADDR, rd, funct3, addr[1:0] and regwrite latched. MEM_ADDR and MEM_REQ stay stable until ack.
- WAIT_MEM on edge with MEM_ACK=1:
  - MEM_REQ falls next cycle.
  - WD3 = extended data, A3 = rd, WE3 = regwrite & (rd != 0), valid in the next cycle.
  - State goes to WRITE.
  - MEM_ACK in the same cycle the request first rises is legal (zero-wait memory).
- Extension: byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- WRITE lasts one cycle; WE3 returns to 0 unless a new accepted non-load write reloads it. A load accepted in WRITE goes to WAIT_MEM (back-to-back throughput).
- MEM_ACK outside WAIT_MEM is ignored.
- EX_RD=0 never asserts WE3; x0 stays zero.
- No forwarding in this block; hazard control belongs to the consumer.

Decomposition:
- Shared package wb_pkg:
  - RESULTSRC encodings (RS_ALU, RS_LOAD, RS_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State encoding (ST_IDLE, ST_WAIT_MEM, ST_WRITE).
- One combinational sub-module, load_extend (inputs funct3, addr[1:0], word; output 32-bit result), reused by a future cache path.

Test Plan:
- Reset, then ALU write: RESULTSRC=00, rd=5, ALURESULT=42 accepted at edge 1 -> WE3=1, A3=5, WD3=42 during cycle 2 only; RD1 of reg 5 reads 42 after edge 3.
- PC+4 with rd=0: RESULTSRC=10, rd=0, PCPLUS4=0x104 -> WE3 stays 0; reg 0 reads 0.
- LB with wait states: addr=0x1003, funct3=000, MEM_RDATA=0x80FF1234, ack after 3 cycles -> MEM_ADDR=0x1000 held stable, EX_READY=0 while waiting, WD3=0xFFFFFF80 to rd=10. Same access as LBU -> 0x00000080.
- LH/LHU on upper half: addr=0x2002, word=0x9ABC0000 -> LH gives 0xFFFF9ABC, LHU gives 0x00009ABC; zero-wait ack (MEM_ACK with the first MEM_REQ cycle) works.
- Misaligned LW: addr=0x3001, funct3=010 -> MISALIGN pulses one cycle, MEM_REQ never rises, WE3=0. Illegal funct3=011 behaves the same.
- Reset mid-load: RST_N low during WAIT_MEM -> MEM_REQ=0 immediately; MEM_ACK arriving after reset release causes no write; the next ALU write to rd=7 completes normally.
